// File: rtl/fc_rr_scheduler.sv
// fc_rr_scheduler
// Shares one fully-connected layer engine between two requesters. The engine is
// granted to one requester for a whole job: N input words streamed in, then M
// result words routed back to that requester. Arbitration is round-robin.
module fc_rr_scheduler #(
   parameter int M = 8,
   parameter int N = 10,
   parameter int T = 16
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic signed [T-1:0] req0_data,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic signed [T-1:0] req1_data,

   output logic                resp0_valid,
   input  logic                resp0_ready,
   output logic                resp1_valid,
   input  logic                resp1_ready,
   output logic signed [T-1:0] resp_data,

   output logic                eng_in_valid,
   input  logic                eng_in_ready,
   output logic signed [T-1:0] eng_in_data,
   input  logic                eng_out_valid,
   output logic                eng_out_ready,
   input  logic signed [T-1:0] eng_out_data,

   output logic                owner,
   output logic                busy,
   output logic                job_done,
   output logic                protocol_err
);

   localparam int MAX_BEATS = (M > N) ? M : N;
   localparam int CW        = $clog2(MAX_BEATS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state_reg;
   logic          owner_reg;
   logic          ptr_reg;
   logic          busy_reg;
   logic          perr_reg;
   logic [CW-1:0] cnt_reg;

   logic [1:0] req_valid_vec;
   logic [1:0] req_ready_vec;
   logic [1:0] resp_valid_vec;
   logic [1:0] resp_ready_vec;
   logic       in_load;
   logic       in_drain;
   logic       in_fire;
   logic       out_fire;
   logic       last_in;
   logic       last_out;
   logic       grant_owner;

   assign req_valid_vec  = {req1_valid, req0_valid};
   assign resp_ready_vec = {resp1_ready, resp0_ready};

   assign in_load  = (state_reg == LOAD);
   assign in_drain = (state_reg == DRAIN);

   // Zero-latency pass-through of the owner's streams; everything is gated by
   // the registered state so an asynchronous reset silences all handshakes.
   assign eng_in_valid  = in_load & req_valid_vec[owner_reg];
   assign eng_in_data   = in_load ? (owner_reg ? req1_data : req0_data) : '0;
   assign eng_out_ready = in_drain & resp_ready_vec[owner_reg];
   assign resp_data     = in_drain ? eng_out_data : '0;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         assign req_ready_vec[gi]  = in_load  & (owner_reg == 1'(gi)) & eng_in_ready;
         assign resp_valid_vec[gi] = in_drain & (owner_reg == 1'(gi)) & eng_out_valid;
      end
   endgenerate

   assign req0_ready  = req_ready_vec[0];
   assign req1_ready  = req_ready_vec[1];
   assign resp0_valid = resp_valid_vec[0];
   assign resp1_valid = resp_valid_vec[1];

   assign in_fire  = eng_in_valid & eng_in_ready;
   assign out_fire = in_drain & eng_out_valid & eng_out_ready;
   assign last_in  = in_fire  & (cnt_reg == CW'(N - 1));
   assign last_out = out_fire & (cnt_reg == CW'(M - 1));

   // A lone requester always wins; on a tie the priority pointer decides.
   assign grant_owner = (req0_valid & req1_valid) ? ptr_reg : req1_valid;

   assign owner        = owner_reg;
   assign busy         = busy_reg;
   assign job_done     = last_out;
   assign protocol_err = perr_reg;

   // Job sequencing: arbitrate, count input beats, count result beats, rotate priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         owner_reg <= 1'b0;
         ptr_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (|req_valid_vec) begin
                  owner_reg <= grant_owner;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= LOAD;
               end
            end
            LOAD: begin
               if (in_fire) begin
                  if (last_in) begin
                     cnt_reg   <= '0;
                     state_reg <= DRAIN;
                  end else begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
            end
            DRAIN: begin
               if (out_fire) begin
                  if (last_out) begin
                     cnt_reg   <= '0;
                     ptr_reg   <= ~owner_reg;
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end else begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Sticky flag for engine results that arrive when no job is draining.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perr_reg <= 1'b0;
      end else if (eng_out_valid && !in_drain) begin
         perr_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fc_rr_scheduler.sv
// tb_fc_rr_scheduler
// Random and directed stimulus for fc_rr_scheduler. A job-level reference model
// predicts every output each cycle; directed phases add literal expectations.
module tb_fc_rr_scheduler;

   localparam int M = 8;
   localparam int N = 10;
   localparam int T = 16;
   localparam int HN = 8192;

   logic clk = 1'b0;
   logic reset;
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic eng_in_valid, eng_in_ready, eng_out_valid, eng_out_ready;
   logic owner, busy, job_done, protocol_err;
   logic signed [T-1:0] req0_data, req1_data, resp_data, eng_in_data, eng_out_data;

   always #5 clk = ~clk;

   fc_rr_scheduler #(.M(M), .N(N), .T(T)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_data(resp_data),
      .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_in_data(eng_in_data),
      .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready), .eng_out_data(eng_out_data),
      .owner(owner), .busy(busy), .job_done(job_done), .protocol_err(protocol_err)
   );

   int n_checks = 0;
   int n_err = 0;
   int cyc = 0;

   // stimulus knobs (percent probabilities and forced holds)
   int p_v[2];
   int p_resp_rdy[2];
   int hold_v[2];
   int p_in_rdy, p_out_v, hold_resp0;
   bit force_out_v;

   // environment: requester word counters and engine model
   int w_idx[2];
   int eng_in_cnt, eng_pending, eng_res_idx, eng_job;

   // reference model state
   bit m_active, m_drain, m_owner, m_ptr, m_perr;
   int m_in, m_out, m_jobs;

   // per-phase observations
   int ph_r0_beats, ph_r1_beats, ph_resp1_cnt, ph_resp1_valid_cnt, ph_r1rdy_own0, first_busy;
   int ph_resp0[$];
   int ph_resp0_cyc[$];
   int ph_ein[$];
   int ph_jd[$];
   int ph_own[$];
   bit busy_h[HN];
   bit owner_h[HN];
   bit r0rdy_h[HN];
   bit prev_busy;

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: cycle budget expired (cycle %0d)", name, cyc);
   endtask

   function automatic bit pct(input int p);
      return ($urandom_range(99) < p);
   endfunction

   function automatic logic signed [T-1:0] word(input int k);
      return T'(k * 1000 + w_idx[k] + 1);
   endfunction

   task automatic drive();
      req0_valid    = (hold_v[0] == 0) && pct(p_v[0]);
      req0_data     = word(0);
      req1_valid    = (hold_v[1] == 0) && pct(p_v[1]);
      req1_data     = word(1);
      eng_in_ready  = pct(p_in_rdy);
      resp0_ready   = (hold_resp0 == 0) && pct(p_resp_rdy[0]);
      resp1_ready   = pct(p_resp_rdy[1]);
      eng_out_valid = force_out_v || (eng_pending > 0 && pct(p_out_v));
      eng_out_data  = T'(100 + 16 * eng_job + eng_res_idx);
   endtask

   // Predict all outputs from the job-level model, compare, then advance the model.
   task automatic check_and_model();
      bit load, drain, e_eiv, e_eor, in_f, out_f, e_jd;
      logic [1:0] rv;
      rv    = {req1_valid, req0_valid};
      load  = m_active && !m_drain;
      drain = m_active && m_drain;
      e_eiv = load && rv[m_owner];
      e_eor = drain && (m_owner ? resp1_ready : resp0_ready);
      in_f  = e_eiv && eng_in_ready;
      out_f = drain && eng_out_valid && e_eor;
      e_jd  = out_f && (m_out == M - 1);

      chk("busy", busy, m_active);
      chk("owner", owner, m_owner);
      chk("eng_in_valid", eng_in_valid, e_eiv);
      chk("req0_ready", req0_ready, load && !m_owner && eng_in_ready);
      chk("req1_ready", req1_ready, load && m_owner && eng_in_ready);
      chk("eng_out_ready", eng_out_ready, e_eor);
      chk("resp0_valid", resp0_valid, drain && !m_owner && eng_out_valid);
      chk("resp1_valid", resp1_valid, drain && m_owner && eng_out_valid);
      chk("job_done", job_done, e_jd);
      chk("protocol_err", protocol_err, m_perr);
      if (e_eiv) chk("eng_in_data", eng_in_data, word(m_owner));
      if (drain && eng_out_valid) chk("resp_data", resp_data, eng_out_data);

      if (eng_out_valid && !drain) m_perr = 1'b1;
      if (!m_active) begin
         if (rv != 2'b00) begin
            m_owner  = (rv == 2'b11) ? m_ptr : rv[1];
            m_active = 1'b1;
            m_drain  = 1'b0;
            m_in     = 0;
            m_out    = 0;
         end
      end else if (!m_drain) begin
         if (in_f) begin
            m_in++;
            if (m_in == N) m_drain = 1'b1;
         end
      end else if (out_f) begin
         m_out++;
         if (m_out == M) begin
            m_active = 1'b0;
            m_ptr    = !m_owner;
            m_jobs++;
         end
      end
   endtask

   task automatic env_update();
      if (req0_valid && req0_ready) begin w_idx[0]++; ph_r0_beats++; end
      if (req1_valid && req1_ready) begin w_idx[1]++; ph_r1_beats++; end
      if (eng_in_valid && eng_in_ready) begin
         ph_ein.push_back(int'(eng_in_data));
         eng_in_cnt++;
         if (eng_in_cnt == N) begin
            eng_in_cnt  = 0;
            eng_pending = M;
            eng_res_idx = 0;
         end
      end
      if (eng_out_valid && eng_out_ready && eng_pending > 0) begin
         eng_res_idx++;
         eng_pending--;
         if (eng_pending == 0) eng_job++;
      end
      if (resp0_valid && resp0_ready) begin
         ph_resp0.push_back(int'(resp_data));
         ph_resp0_cyc.push_back(cyc);
      end
      if (resp1_valid && resp1_ready) ph_resp1_cnt++;
      if (resp1_valid) ph_resp1_valid_cnt++;
      if (busy && !owner && req1_ready) ph_r1rdy_own0++;
      if (job_done) ph_jd.push_back(cyc);
      if (busy && !prev_busy) begin
         ph_own.push_back(int'(owner));
         if (first_busy < 0) first_busy = cyc;
      end
      prev_busy        = busy;
      busy_h[cyc % HN]  = busy;
      owner_h[cyc % HN] = owner;
      r0rdy_h[cyc % HN] = req0_ready;
      if (hold_v[0] > 0) hold_v[0]--;
      if (hold_v[1] > 0) hold_v[1]--;
      if (hold_resp0 > 0) hold_resp0--;
   endtask

   task automatic step();
      drive();
      @(negedge clk);
      check_and_model();
      env_update();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_job_done", job_done, 0);
      chk("rst_protocol_err", protocol_err, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_resp0_valid", resp0_valid, 0);
      chk("rst_resp1_valid", resp1_valid, 0);
      chk("rst_eng_in_valid", eng_in_valid, 0);
      chk("rst_eng_out_ready", eng_out_ready, 0);
      m_active = 0; m_drain = 0; m_owner = 0; m_ptr = 0; m_perr = 0; m_in = 0; m_out = 0;
      eng_in_cnt = 0; eng_pending = 0; eng_res_idx = 0;
      hold_v[0] = 0; hold_v[1] = 0; hold_resp0 = 0; force_out_v = 0; prev_busy = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic run_jobs(input int n, input int budget, input string name);
      int tgt, c;
      tgt = m_jobs + n;
      c = 0;
      while (m_jobs < tgt && c < budget) begin step(); c++; end
      if (m_jobs < tgt) timeout(name);
   endtask

   task automatic go_idle();
      int c;
      p_v[0] = 0;
      p_v[1] = 0;
      c = 0;
      while (m_active && c < 600) begin step(); c++; end
      if (m_active) timeout("go_idle");
      step();
   endtask

   task automatic clear_phase();
      ph_r0_beats = 0; ph_r1_beats = 0; ph_resp1_cnt = 0; ph_resp1_valid_cnt = 0;
      ph_r1rdy_own0 = 0; first_busy = -1;
      ph_resp0.delete(); ph_resp0_cyc.delete(); ph_ein.delete(); ph_jd.delete(); ph_own.delete();
   endtask

   task automatic set_rates(input int in_rdy, input int rsp_rdy, input int out_v);
      p_in_rdy      = in_rdy;
      p_resp_rdy[0] = rsp_rdy;
      p_resp_rdy[1] = rsp_rdy;
      p_out_v       = out_v;
   endtask

   initial begin
      int c, base, w0, hold_start, in_hold;
      reset = 1'b1;
      req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
      resp0_ready = 0; resp1_ready = 0; eng_in_ready = 0; eng_out_valid = 0; eng_out_data = '0;
      p_v[0] = 0; p_v[1] = 0; hold_v[0] = 0; hold_v[1] = 0; hold_resp0 = 0; force_out_v = 0;
      w_idx[0] = 0; w_idx[1] = 0; eng_job = 0; m_jobs = 0;
      set_rates(100, 100, 100);
      clear_phase();
      #2;
      do_reset();

      // single requester, zero stalls
      clear_phase();
      p_v[0] = 100;
      run_jobs(1, 200, "single");
      p_v[0] = 0;
      chk("single_req0_beats", ph_r0_beats, N);
      chk("single_resp0_count", ph_resp0.size(), M);
      for (int j = 0; j < M && j < ph_resp0.size(); j++) chk("single_resp0_data", ph_resp0[j], 100 + j);
      for (int j = 0; j < N && j < ph_ein.size(); j++) chk("single_eng_in_data", ph_ein[j], j + 1);
      chk("single_job_done_count", ph_jd.size(), 1);
      if (ph_jd.size() >= 1) chk("single_job_length", ph_jd[0] - first_busy, N + M - 1);
      if (ph_jd.size() >= 1 && ph_resp0_cyc.size() >= M)
         chk("single_jd_on_last_result", ph_jd[0], ph_resp0_cyc[M-1]);
      chk("single_resp1_valid", ph_resp1_valid_cnt, 0);
      if (ph_own.size() >= 1) chk("single_owner", ph_own[0], 0);
      go_idle();

      // simultaneous requests right after reset
      do_reset();
      clear_phase();
      p_v[0] = 100; p_v[1] = 100;
      run_jobs(2, 300, "simul");
      chk("simul_jobs", ph_own.size(), 2);
      if (ph_own.size() >= 2) begin
         chk("simul_owner_job1", ph_own[0], 0);
         chk("simul_owner_job2", ph_own[1], 1);
      end
      chk("simul_req1_ready_in_job1", ph_r1rdy_own0, 0);
      if (ph_jd.size() >= 1) begin
         chk("simul_idle_after_done", busy_h[(ph_jd[0] + 1) % HN], 0);
         chk("simul_busy_two_after_done", busy_h[(ph_jd[0] + 2) % HN], 1);
         chk("simul_owner_two_after_done", owner_h[(ph_jd[0] + 2) % HN], 1);
      end

      // fairness with both requesters always valid, random engine timing
      clear_phase();
      set_rates(70, 70, 70);
      run_jobs(4, 1000, "fair");
      chk("fair_jobs", ph_own.size(), 4);
      for (int j = 0; j < 4 && j < ph_own.size(); j++) chk("fair_owner", ph_own[j], j % 2);
      go_idle();

      // stalls: random input readiness, resp0_ready forced low mid-drain
      clear_phase();
      set_rates(60, 70, 70);
      base = 100 + 16 * eng_job;
      w0 = w_idx[0];
      p_v[0] = 100;
      c = 0;
      while (!(m_active && m_drain && m_out >= 3) && c < 400) begin step(); c++; end
      if (!(m_active && m_drain)) timeout("stall_reach_drain");
      hold_resp0 = 5;
      hold_start = cyc;
      run_jobs(1, 400, "stall");
      p_v[0] = 0;
      chk("stall_resp0_count", ph_resp0.size(), M);
      for (int j = 0; j < M && j < ph_resp0.size(); j++) chk("stall_resp0_data", ph_resp0[j], base + j);
      chk("stall_ein_count", ph_ein.size(), N);
      for (int j = 0; j < N && j < ph_ein.size(); j++) chk("stall_ein_data", ph_ein[j], w0 + j + 1);
      in_hold = 0;
      foreach (ph_resp0_cyc[j]) if (ph_resp0_cyc[j] >= hold_start && ph_resp0_cyc[j] < hold_start + 5) in_hold++;
      chk("stall_no_beat_in_hold", in_hold, 0);
      go_idle();

      // requester 1 gap of 20 cycles after 4 words
      clear_phase();
      set_rates(100, 100, 100);
      p_v[1] = 100;
      c = 0;
      while (ph_r1_beats < 4 && c < 100) begin step(); c++; end
      if (ph_r1_beats < 4) timeout("gap_first_words");
      hold_v[1] = 20;
      p_v[0] = 100;
      for (int j = 0; j < 20; j++) begin
         step();
         chk("gap_busy", busy_h[(cyc - 1) % HN], 1);
         chk("gap_owner", owner_h[(cyc - 1) % HN], 1);
         chk("gap_req0_ready", r0rdy_h[(cyc - 1) % HN], 0);
      end
      chk("gap_beats_held", ph_r1_beats, 4);
      p_v[0] = 0;
      run_jobs(1, 200, "gap");
      chk("gap_total_beats", ph_r1_beats, N);
      chk("gap_resp1_beats", ph_resp1_cnt, M);
      if (ph_own.size() >= 1) chk("gap_owner_job", ph_own[0], 1);
      go_idle();

      // reset after 6 input beats, then a full job
      clear_phase();
      p_v[0] = 100;
      c = 0;
      while (ph_r0_beats < 6 && c < 100) begin step(); c++; end
      if (ph_r0_beats < 6) timeout("rst_first_words");
      do_reset();
      clear_phase();
      run_jobs(1, 200, "post_reset");
      p_v[0] = 0;
      chk("post_reset_req0_beats", ph_r0_beats, N);
      chk("post_reset_ein_count", ph_ein.size(), N);
      chk("post_reset_resp0_count", ph_resp0.size(), M);
      go_idle();

      // engine result while idle raises a sticky protocol error
      step();
      chk("perr_before", protocol_err, 0);
      force_out_v = 1;
      step();
      force_out_v = 0;
      chk("perr_set", protocol_err, 1);
      for (int j = 0; j < 4; j++) begin
         step();
         chk("perr_sticky", protocol_err, 1);
      end
      do_reset();
      step();
      chk("perr_after_reset", protocol_err, 0);

      // random traffic from both requesters
      clear_phase();
      p_v[0] = 60; p_v[1] = 60;
      set_rates(70, 70, 70);
      run_jobs(12, 4000, "random");
      go_idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/fc_rr_scheduler.md
# fc_rr_scheduler

Round-robin scheduler that shares one fully-connected layer engine between two vector requesters. It sits between two producer streams and the FC engine's valid/ready input/output ports. It grants the engine to one requester for a whole job: N input words in, M result words out. It then routes the engine's results back to the granted requester's response port.

## Interface
- M, 8, result words produced by the engine per job
- N, 10, input words consumed by the engine per job
- T, 16, data word width (signed)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- req0_valid / req1_valid  input  1  requester k presents an input word
- req0_ready / req1_ready  output  1  requester k word accepted this cycle
- req0_data / req1_data  input  T  requester k input word (signed)
- resp0_valid / resp1_valid  output  1  result word available to requester k
- resp0_ready / resp1_ready  input  1  requester k can take a result word
- resp_data  output  T  result word, shared by both responders; meaningful only with respk_valid
- eng_in_valid  output  1  word presented to the engine input
- eng_in_ready  input  1  engine accepts an input word
- eng_in_data  output  T  word to the engine
- eng_out_valid  input  1  engine result word available
- eng_out_ready  output  1  scheduler takes an engine result
- eng_out_data  input  T  engine result word
- owner  output  1  index of the granted requester; held after a job ends
- busy  output  1  high in LOAD and DRAIN
- job_done  output  1  one-cycle pulse on the final result beat of a job
- protocol_err  output  1  sticky; set when eng_out_valid is seen outside DRAIN

## Operation
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - All readies and valids are 0.
  - If any reqk_valid is high, latch owner, clear the beat counter, and go to LOAD.
  - If both are valid, the requester selected by the priority pointer wins.
- Priority pointer:
  - Reset value favours requester 0.
  - After each completed job it points at the requester that did not own that job.
- LOAD (combinational pass-through, owner only):
  - eng_in_valid = req[owner]_valid
  - req[owner]_ready = eng_in_ready
  - eng_in_data = req[owner]_data
  - The non-owner's ready is 0.
  - The beat counter increments on each eng_in_valid and eng_in_ready beat.
  - On the N-th beat, clear the counter and go to DRAIN.
- DRAIN:
  - resp[owner]_valid = eng_out_valid
  - eng_out_ready = resp[owner]_ready
  - resp_data = eng_out_data
  - Non-owner resp valid is 0. eng_in_valid is 0.
  - The counter increments on each accepted result beat.
  - On the M-th beat: pulse job_done, toggle the pointer, go to IDLE.
- Jobs are never preempted. A requester that drops valid mid-vector holds the scheduler in LOAD indefinitely.
- Outside DRAIN, eng_out_ready is 0. If eng_out_valid is high there, set protocol_err; it clears only on reset.
- Beat counter width: $clog2(max(M,N)+1).
- Data is passed unmodified; no arithmetic on T-bit words.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE, counter 0, pointer to requester 0.
  - owner, busy, job_done, protocol_err = 0.
  - All valid and ready outputs = 0.
- Arbitration costs exactly 1 cycle. A request valid in cycle c can first be accepted in cycle c+1.
- Handshakes through the scheduler add zero latency in both directions (combinational).
- The last input beat in cycle c puts the scheduler in DRAIN at c+1. The engine may return results any time after that.
- The last result beat in cycle c gives:
  - job_done high in cycle c
  - IDLE at c+1
  - the next grant decided at c+1
  - next LOAD at c+2
- Minimum job length is N + M + 1 cycles, given zero stalls.
- Back-pressure: resp[owner]_ready low stalls the engine output with no beat loss. eng_in_ready low stalls the requester.
- busy is high exactly in the LOAD and DRAIN states.
- If reset asserts mid-job, all outputs drop immediately and the partial job is discarded. The engine must be reset alongside.

## Test plan
- **Single requester:** req0 streams words 1..10 with an engine model returning 8 words 100..107. Check:
  - req0 gets 10 ready beats.
  - resp0 gets 100..107.
  - job_done pulses once, with the 8th result.
  - resp1_valid stays 0 and owner = 0.
- **Simultaneous requests after reset:** req0 and req1 both valid. Check:
  - Job 1 is owned by 0 and job 2 by 1.
  - req1_ready = 0 throughout job 1.
  - req1 is granted exactly 1 cycle after job 1's job_done.
- **Fairness:** req0 and req1 both valid continuously for 4 jobs. Owners must be 0,1,0,1.
- **Stalls:** random eng_in_ready and resp0_ready held low for 5 cycles mid-DRAIN. There must be no lost or duplicated beats, and the data order must be preserved.
- **Requester gap:** req1 drops valid after 4 words for 20 cycles. Check:
  - The scheduler stays in LOAD, owner = 1, req0_ready = 0.
  - The job completes normally afterwards.
- **Reset and protocol error:**
  - Assert reset after 6 input beats: all outputs go to 0 immediately, and after release the next job accepts a full 10 beats.
  - Drive eng_out_valid in IDLE: protocol_err goes to 1 and stays 1 until reset.
